uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_tx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit FIFO.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef enum logic {IDLE, REQ} tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x 8 array, one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_start/tx_accept handshake.
// Define UART_TX_FIFO_STATS_EN to add the saturating drop_cnt output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef UART_TX_FIFO_STATS_EN
  output logic [15:0]            drop_cnt,
`endif
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [LW-1:0]          level,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_byte,
  input  logic                   tx_ready,
  input  logic                   tx_accept
);

  localparam int unsigned AW = $clog2(DEPTH);

  tx_state_e     state_q, state_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;

  // The transmitter's idle flag is not needed: tx_accept alone marks a load.
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign overflow = overflow_q;

  assign pop  = (state_q == REQ) && tx_accept;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (wr_data),
    .raddr (rptr_q),
    .rdata (tx_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (level_q != '0) state_d = REQ;
      REQ:  if (pop && (level_q <= LW'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_q == REQ);
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] drop_cnt_q;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (clr_overflow) begin
        drop_cnt_q <= 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end else if (clr_overflow) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16).
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow;
  logic [4:0] level;
  logic       clr_overflow;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_accept;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk          (clk),
    .rst          (rst),
`ifdef UART_TX_FIFO_STATS_EN
    .drop_cnt     (drop_cnt),
`endif
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx_ready     (tx_ready),
    .tx_accept    (tx_accept)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
    tx_ready = 1'b1; tx_accept = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Single byte: write at N, tx_start at N+2, one accept drains it.
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("lat_level_n1", 32'(level), 32'd1);
    check("lat_start_n1", 32'(tx_start), 32'd0);
    tick();
    check("lat_start_n2", 32'(tx_start), 32'd1);
    check("lat_byte_n2", 32'(tx_byte), 32'h55);
    tx_accept = 1'b1;
    tick();
    tx_accept = 1'b0;
    check("one_level_after_pop", 32'(level), 32'd0);
    check("one_empty_after_pop", 32'(empty), 32'd1);
    check("one_start_after_pop", 32'(tx_start), 32'd0);

    // Fill with 01..10 back-to-back.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    check("fill_level", 32'(level), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_overflow", 32'(overflow), 32'd0);
    check("fill_head", 32'(tx_byte), 32'h01);
    check("fill_start", 32'(tx_start), 32'd1);

    // Write while full without pop is dropped.
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("drop_level", 32'(level), 32'd16);
    check("drop_overflow", 32'(overflow), 32'd1);
`ifdef UART_TX_FIFO_STATS_EN
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif

    // Clear together with another drop: drop wins.
    wr_en = 1'b1; wr_data = 8'hCC; clr_overflow = 1'b1;
    tick();
    wr_en = 1'b0;
    check("clr_drop_overflow", 32'(overflow), 32'd1);
`ifdef UART_TX_FIFO_STATS_EN
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    tick();
    clr_overflow = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_STATS_EN
    check("clr_cnt", 32'(drop_cnt), 32'd0);
`endif

    // At full, write BB alongside a pop: accepted.
    wr_en = 1'b1; wr_data = 8'hBB; tx_accept = 1'b1;
    tick();
    wr_en = 1'b0; tx_accept = 1'b0;
    check("full_wp_level", 32'(level), 32'd16);
    check("full_wp_overflow", 32'(overflow), 32'd0);

    // Drain: 02..10 then BB; AA and CC never appear.
    for (int i = 0; i < 16; i++) begin
      check("drain_start", 32'(tx_start), 32'd1);
      check("drain_byte", 32'(tx_byte), (i < 15) ? 32'(i + 2) : 32'hBB);
      tx_accept = 1'b1;
      tick();
      tx_accept = 1'b0;
      tick();
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_start_end", 32'(tx_start), 32'd0);

    // Accept while still IDLE (level=1, request not yet raised) is ignored.
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0; tx_accept = 1'b1;
    tick();
    tx_accept = 1'b0;
    check("idle_accept_level", 32'(level), 32'd1);
    check("idle_accept_start", 32'(tx_start), 32'd1);
    check("idle_accept_byte", 32'(tx_byte), 32'h77);
    tx_accept = 1'b1;
    tick();
    tx_accept = 1'b0;
    check("idle_accept_drain", 32'(level), 32'd0);

    // Five entries, a simultaneous write+pop, then reset mid-request.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check("r5_level", 32'(level), 32'd5);
    check("r5_start", 32'(tx_start), 32'd1);
    check("r5_head", 32'(tx_byte), 32'hA0);
    wr_en = 1'b1; wr_data = 8'hA5; tx_accept = 1'b1;
    tick();
    wr_en = 1'b0; tx_accept = 1'b0;
    check("wp_level", 32'(level), 32'd5);
    check("wp_head", 32'(tx_byte), 32'hA1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    tx_accept = 1'b1;
    tick();
    tx_accept = 1'b0;
    check("post_rst_accept_level", 32'(level), 32'd0);
    check("post_rst_accept_start", 32'(tx_start), 32'd0);
    tick();
    check("post_rst_idle_start", 32'(tx_start), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
